audio_sample_fifo: RTL
======================

// Module: audio_sample_fifo
// PURPOSE
//  Parametrised single-clock first-word-fall-through (FWFT) FIFO for audio sample streams.
//  Built on a synchronous simple-dual-port RAM with a 1-cycle read, plus a prefetch/skid output stage.
//  Adds valid/ready handshakes, fill level, almost flags, flush and sticky overflow on both sides.
//  Sits between the codec/I2S capture path and the DSP/processing pipeline.
// PARAMETERS
//  DATA_WIDTH     16     sample width in bits
//  ADDR_WIDTH     10     RAM address width; DEPTH = 2**ADDR_WIDTH (1024)
//  AFULL_THRESH   1000   almost_full asserts when level >= AFULL_THRESH
//  AEMPTY_THRESH  16     almost_empty asserts when level <= AEMPTY_THRESH
// PORTS
//  clk           in   1             single clock, rising edge
//  rst           in   1             synchronous reset, active-high
//  flush         in   1             synchronous clear of contents (same effect as rst, 1 cycle)
//  in_data       in   DATA_WIDTH    write sample
//  in_valid      in   1             write request
//  in_ready      out  1             = ~full (registered, no pop->push bypass)
//  out_data      out  DATA_WIDTH    head sample, valid while out_valid
//  out_valid     out  1             head sample present
//  out_ready     in   1             consumer accepts head
//  level         out  ADDR_WIDTH+1  words accepted and not yet popped (RAM + in-flight + output stage)
//  almost_full   out  1             level >= AFULL_THRESH
//  almost_empty  out  1             level <= AEMPTY_THRESH
//  overflow      out  1             sticky: set when in_valid & ~in_ready
// BEHAVIOUR
//  - Reset / flush: wr_ptr, rd_ptr, level, output stage and in-flight read cleared.
//    Outputs after reset: in_ready=1, out_valid=0, out_data=0, level=0, almost_full=0,
//    almost_empty=1, overflow=0. RAM contents are not cleared.
//  - Push = in_valid & in_ready; pop = out_valid & out_ready. level += push, -= pop; both in the
//    same cycle leave level unchanged.
//  - Full: level == DEPTH; in_ready=0 even if pop in same cycle (next cycle in_ready=1).
//  - Pointers are ADDR_WIDTH bits and wrap naturally at DEPTH-1 -> 0.
//  - Prefetch: a RAM read is issued when RAM holds unread words and output stage + in-flight < stage capacity.
//    Stage capacity is 2 (3 with the output register). Back-to-back pops at 1 word/clk sustained.
//  - Latency: push in cycle N -> out_valid=1 in cycle N+2 (empty FIFO, no write->read bypass).
//  - out_data is held stable while out_valid & ~out_ready. Order is strictly preserved.
//  - Mid-operation rst/flush discards in-flight read data. A push in the flush cycle is dropped.
//  - overflow is cleared only by rst/flush. Pop while ~out_valid is ignored (no flag).
// CONFIGURATION
//  `AUDIO_SAMPLE_FIFO_OUTREG_EN defined: extra output register after the RAM read.
//    Stage capacity is 3; empty-FIFO latency is N+3; out_data is driven directly from a flop.
//  Undefined: RAM read data feeds the 2-entry skid stage directly; latency N+2.
//  Throughput and level semantics are identical in both builds.
// STRUCTURE
//  audio_buf_pkg: DEPTH calc, default widths/thresholds, level width function.
//  Sub-module audio_sdpram: sync simple-dual-port RAM, 1-cycle read, no reset on array.
//  Top holds pointers, level counter, prefetch control, output stage and flags.
// TESTING
//  1 rst, then push 0x0001..0x0004 one per clk, out_ready=1 -> out_valid first at push0+2,
//    data 0x0001..0x0004 in order, level returns 0.
//  2 Fill 1024 words, out_ready=0 -> level=1024, in_ready=0, almost_full from level 1000.
//    Extra in_valid -> overflow=1 and stays 1.
//  3 Full, then push+pop in the same cycle -> push refused; level goes 1023; next cycle in_ready=1.
//  4 Stream 3000 words with random out_ready (50%) -> no loss/dup across pointer wrap,
//    out_data stable while stalled.
//  5 Load 10 words, assert flush mid-read -> next cycle level=0, out_valid=0, overflow=0;
//    new push 0xBEEF is the next word out.
//  6 Repeat 1 and 4 with `AUDIO_SAMPLE_FIFO_OUTREG_EN -> latency N+3, same data order.

Source files
------------

// File: rtl/audio_sample_fifo_pkg.sv
// Shared sizing defaults and helpers for the audio sample FIFO.
package audio_sample_fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF    = 16;
    localparam int unsigned ADDR_WIDTH_DEF    = 10;
    localparam int unsigned AFULL_THRESH_DEF  = 1000;
    localparam int unsigned AEMPTY_THRESH_DEF = 16;

    // Number of RAM words for a given address width.
    function automatic int unsigned depth_of(input int unsigned addr_width);
        return 32'(1) << addr_width;
    endfunction

    // Level counter must represent 0..DEPTH inclusive.
    function automatic int unsigned level_width(input int unsigned addr_width);
        return addr_width + 32'd1;
    endfunction

endpackage

// File: rtl/audio_sample_fifo_sdpram.sv
// Synchronous simple-dual-port RAM: one write port, one read port, 1-cycle registered read.
// Array is not reset; read data holds its value when no read is issued.
module audio_sample_fifo_sdpram
    import audio_sample_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/audio_sample_fifo.sv
// First-word-fall-through sample FIFO between capture path and DSP pipeline.
// Build option: AUDIO_SAMPLE_FIFO_OUTREG_EN adds an output register after the RAM read
// (3-deep prefetch, out_data straight from a flop); otherwise the RAM read data feeds a
// 2-deep skid stage directly.
module audio_sample_fifo
    import audio_sample_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int unsigned AFULL_THRESH  = AFULL_THRESH_DEF,
    parameter int unsigned AEMPTY_THRESH = AEMPTY_THRESH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow
);

    localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
    localparam int unsigned LW    = level_width(ADDR_WIDTH);

    localparam logic [LW-1:0] FULL_LEVEL   = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_LEVEL  = LW'(AFULL_THRESH);
    localparam logic [LW-1:0] AEMPTY_LEVEL = LW'(AEMPTY_THRESH);

    logic                  clr;
    logic                  push;
    logic                  pop;
    logic                  rd_en;
    logic                  ram_has;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [LW-1:0]         level_nxt;
    logic [LW-1:0]         occ;

    assign clr     = rst | flush;
    assign push    = in_valid & in_ready & ~clr;
    assign pop     = out_valid & out_ready & ~clr;
    // Everything counted in level but not yet in the output stage is still unread in RAM.
    assign ram_has = (level != occ);

    audio_sample_fifo_sdpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

`ifdef AUDIO_SAMPLE_FIFO_OUTREG_EN

    // Output register (out_valid/out_data) + second slot + word parked on RAM read data.
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  p_valid;
    logic                  h_keep;
    logic [DATA_WIDTH-1:0] hd_keep;
    logic                  s_keep;
    logic                  land;
    logic                  h_valid_nxt;
    logic [DATA_WIDTH-1:0] h_data_nxt;
    logic                  s_valid_nxt;
    logic [DATA_WIDTH-1:0] s_data_nxt;
    logic                  p_valid_nxt;

    assign occ = LW'(out_valid) + LW'(s_valid) + LW'(p_valid);

    // Shift on pop, land the parked RAM word in the first free slot, prefetch while room remains.
    always_comb begin
        h_keep      = pop ? s_valid : out_valid;
        hd_keep     = pop ? s_data : out_data;
        s_keep      = s_valid & ~pop;
        land        = p_valid & ~(h_keep & s_keep);
        rd_en       = ram_has & ~clr & ~(h_keep & s_keep & p_valid);
        h_valid_nxt = h_keep | land;
        h_data_nxt  = h_keep ? hd_keep : ram_q;
        s_valid_nxt = s_keep | (land & h_keep);
        s_data_nxt  = s_keep ? s_data : ram_q;
        p_valid_nxt = rd_en | (p_valid & ~land);
    end

    // Output stage registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            s_valid   <= 1'b0;
            s_data    <= '0;
            p_valid   <= 1'b0;
        end else begin
            out_valid <= h_valid_nxt;
            out_data  <= h_data_nxt;
            s_valid   <= s_valid_nxt;
            s_data    <= s_data_nxt;
            p_valid   <= p_valid_nxt;
        end
    end

`else

    // Skid slot holds the older word; the RAM read register holds the younger one.
    logic                  q_valid;
    logic                  sk_valid;
    logic [DATA_WIDTH-1:0] sk_data;
    logic                  sk_keep;
    logic                  q_keep;
    logic                  sk_load;
    logic                  sk_valid_nxt;
    logic                  q_valid_nxt;

    assign occ = LW'(sk_valid) + LW'(q_valid);

    // Pop takes the skid word first; a new read moves a surviving RAM word into the skid slot.
    always_comb begin
        sk_keep      = sk_valid & ~pop;
        q_keep       = q_valid & ~(pop & ~sk_valid);
        rd_en        = ram_has & ~clr & ~(sk_keep & q_keep);
        sk_load      = rd_en & q_keep;
        sk_valid_nxt = sk_keep | sk_load;
        q_valid_nxt  = q_keep | rd_en;
    end

    // Skid stage registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            q_valid   <= 1'b0;
            sk_valid  <= 1'b0;
            sk_data   <= '0;
            out_valid <= 1'b0;
        end else begin
            q_valid   <= q_valid_nxt;
            sk_valid  <= sk_valid_nxt;
            if (sk_load) begin
                sk_data <= ram_q;
            end
            out_valid <= sk_valid_nxt | q_valid_nxt;
        end
    end

    assign out_data = sk_valid ? sk_data : (q_valid ? ram_q : '0);

`endif

    // Next fill level from accepted push/pop.
    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + LW'(1);
        end else if (pop && !push) begin
            level_nxt = level - LW'(1);
        end
    end

    // RAM pointers; wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    // Level, registered handshake/status flags and sticky overflow.
    always_ff @(posedge clk) begin
        if (clr) begin
            level        <= '0;
            in_ready     <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
        end else begin
            level        <= level_nxt;
            in_ready     <= (level_nxt != FULL_LEVEL);
            almost_full  <= (level_nxt >= AFULL_LEVEL);
            almost_empty <= (level_nxt <= AEMPTY_LEVEL);
            overflow     <= overflow | (in_valid & ~in_ready);
        end
    end

endmodule
